// File: rtl/r5p_htif_responder.sv
// r5p_htif_responder
// Minimal HTIF-style host interface on the TCB system bus (DLY=1).
// It provides a tohost/fromhost mailbox, halt and exit-code capture, and
// console byte output through a small FIFO.
//
// Register window (only tcb_adr[3:0] is decoded; BASE selection is upstream):
//   0x0 TOHOST   rw  a write with bit0=1 sets halt and captures exit_code once
//   0x4 FROMHOST rw  host_vld loads host_dat and wins over a CPU write
//   0x8 CONSOLE  wo  pushes wdt[7:0] into the console FIFO, reads 0
//   0xC STATUS   ro  [0] halt, [1] full, [2] empty, [15:8] level
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   tcb_vld/wen/adr/fn3/wdt   TCB request
//   tcb_rdt/err        TCB response, registered, one cycle after transfer
//   tcb_rdy            TCB ready (combinational, low only on a full-FIFO
//                      console write)
//   host_vld/host_dat  host-side fromhost write
//   halt/exit_code     sticky halt flag and captured exit code
//   con_vld/dat/rdy    console byte stream
//
// Build option: define R5P_HTIF_CONSOLE_EN to build the console FIFO.
// Without it, console writes are accepted and discarded, STATUS reports an
// empty FIFO, and the con_* stream is held idle.
module r5p_htif_responder #(
  parameter logic [31:0] BASE     = 32'h8020_0000,
  parameter int unsigned FIFO_DEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcb_vld,
  input  logic        tcb_wen,
  input  logic [31:0] tcb_adr,
  input  logic [2:0]  tcb_fn3,
  input  logic [31:0] tcb_wdt,
  output logic [31:0] tcb_rdt,
  output logic        tcb_err,
  output logic        tcb_rdy,
  input  logic        host_vld,
  input  logic [31:0] host_dat,
  output logic        halt,
  output logic [30:0] exit_code,
  output logic        con_vld,
  output logic [7:0]  con_dat,
  input  logic        con_rdy
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 31;
  localparam int unsigned BW = 8;

  localparam logic [1:0] OFF_TOHOST   = 2'd0;
  localparam logic [1:0] OFF_FROMHOST = 2'd1;
  localparam logic [1:0] OFF_CONSOLE  = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  // registers
  logic [DW-1:0] rdt_q, rdt_d;
  logic          err_q, err_d;
  logic [DW-1:0] tohost_q, tohost_d;
  logic [DW-1:0] fromhost_q, fromhost_d;
  logic          halt_q, halt_d;
  logic [EW-1:0] exit_q, exit_d;

  // decode
  logic          word_c;
  logic [1:0]    off_c;
  logic          con_req_c;
  logic          trn_c;
  logic          wr_acc_c;
  logic [DW-1:0] rd_mux_c;
  logic [DW-1:0] status_c;

  // console FIFO status (constant when the FIFO is not built)
  logic          fifo_full_c;
  logic          fifo_empty_c;
  logic [BW-1:0] fifo_lvl_c;

  // Request decode; the stall condition must not depend on con_rdy.
  always_comb begin
    word_c    = (tcb_fn3[1:0] == 2'b10) && (tcb_adr[1:0] == 2'b00);
    off_c     = tcb_adr[3:2];
    con_req_c = tcb_vld && tcb_wen && word_c && (off_c == OFF_CONSOLE);
    tcb_rdy   = !(con_req_c && fifo_full_c);
    trn_c     = tcb_vld && tcb_rdy;
    wr_acc_c  = trn_c && word_c && tcb_wen;
  end

  // Read data selection
  always_comb begin
    status_c = {16'h0000, fifo_lvl_c, 5'b00000, fifo_empty_c, fifo_full_c, halt_q};
    rd_mux_c = '0;
    case (off_c)
      OFF_TOHOST:   rd_mux_c = tohost_q;
      OFF_FROMHOST: rd_mux_c = fromhost_q;
      OFF_CONSOLE:  rd_mux_c = '0;
      OFF_STATUS:   rd_mux_c = status_c;
      default:      rd_mux_c = '0;
    endcase
  end

  // Next-state for response and mailbox registers
  always_comb begin
    rdt_d      = rdt_q;
    err_d      = err_q;
    tohost_d   = tohost_q;
    fromhost_d = fromhost_q;
    halt_d     = halt_q;
    exit_d     = exit_q;

    // Response registers only change on a transfer, so they hold through stalls.
    if (trn_c) begin
      err_d = !word_c;
      rdt_d = (word_c && !tcb_wen) ? rd_mux_c : '0;
    end

    if (wr_acc_c && (off_c == OFF_TOHOST)) begin
      tohost_d = tcb_wdt;
      // exit_code is captured only by the first halting write
      if (tcb_wdt[0] && !halt_q) begin
        halt_d = 1'b1;
        exit_d = tcb_wdt[DW-1:1];
      end
    end

    if (wr_acc_c && (off_c == OFF_FROMHOST)) begin
      fromhost_d = tcb_wdt;
    end

    // host side has priority over a simultaneous CPU write
    if (host_vld) begin
      fromhost_d = host_dat;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdt_q      <= '0;
      err_q      <= 1'b0;
      tohost_q   <= '0;
      fromhost_q <= '0;
      halt_q     <= 1'b0;
      exit_q     <= '0;
    end else begin
      rdt_q      <= rdt_d;
      err_q      <= err_d;
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
      halt_q     <= halt_d;
      exit_q     <= exit_d;
    end
  end

  assign tcb_rdt   = rdt_q;
  assign tcb_err   = err_q;
  assign halt      = halt_q;
  assign exit_code = exit_q;

`ifdef R5P_HTIF_CONSOLE_EN

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned IW = $clog2(FIFO_DEP);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] lvl_c;
  logic [BW-1:0] mem_q [FIFO_DEP];
  logic          push_c;
  logic          pop_c;

  // FIFO status and pointer next-state
  always_comb begin
    lvl_c        = wptr_q - rptr_q;
    fifo_full_c  = (lvl_c == PW'(FIFO_DEP));
    fifo_empty_c = (lvl_c == '0);
    fifo_lvl_c   = BW'(lvl_c);
    // the stall guarantees a push never hits a full FIFO
    push_c       = wr_acc_c && (off_c == OFF_CONSOLE);
    pop_c        = !fifo_empty_c && con_rdy;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    if (push_c) wptr_d = wptr_q + PW'(1);
    if (pop_c)  rptr_d = rptr_q + PW'(1);
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; empty entries are never presented.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q[IW-1:0]] <= tcb_wdt[BW-1:0];
    end
  end

  // Head entry, forced to zero while empty
  always_comb begin
    con_vld = !fifo_empty_c;
    con_dat = fifo_empty_c ? '0 : mem_q[rptr_q[IW-1:0]];
  end

  logic unused_ok;
  assign unused_ok = ^{tcb_adr[31:4], tcb_fn3[2], BASE};

`else

  // Console disabled: writes are accepted and dropped, FIFO reads as empty.
  always_comb begin
    fifo_full_c  = 1'b0;
    fifo_empty_c = 1'b1;
    fifo_lvl_c   = '0;
    con_vld      = 1'b0;
    con_dat      = '0;
  end

  logic unused_ok;
  assign unused_ok = ^{tcb_adr[31:4], tcb_fn3[2], BASE, con_rdy, 32'(FIFO_DEP)};

`endif

endmodule

// File: tb/tb_r5p_htif_responder.sv
module tb_r5p_htif_responder;

  localparam logic [31:0] BASE = 32'h8020_0000;
  localparam int unsigned DEP  = 4;
`ifdef R5P_HTIF_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif

  localparam logic [31:0] A_TO  = BASE + 32'h0;
  localparam logic [31:0] A_FR  = BASE + 32'h4;
  localparam logic [31:0] A_CON = BASE + 32'h8;
  localparam logic [31:0] A_ST  = BASE + 32'hC;

  logic        clk, rst;
  logic        tcb_vld, tcb_wen;
  logic [31:0] tcb_adr;
  logic [2:0]  tcb_fn3;
  logic [31:0] tcb_wdt;
  logic [31:0] tcb_rdt;
  logic        tcb_err, tcb_rdy;
  logic        host_vld;
  logic [31:0] host_dat;
  logic        halt;
  logic [30:0] exit_code;
  logic        con_vld;
  logic [7:0]  con_dat;
  logic        con_rdy;

  r5p_htif_responder #(.BASE(BASE), .FIFO_DEP(DEP)) dut (
    .clk(clk), .rst(rst),
    .tcb_vld(tcb_vld), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr), .tcb_fn3(tcb_fn3),
    .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err), .tcb_rdy(tcb_rdy),
    .host_vld(host_vld), .host_dat(host_dat),
    .halt(halt), .exit_code(exit_code),
    .con_vld(con_vld), .con_dat(con_dat), .con_rdy(con_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural reference state
  logic [31:0] m_tohost, m_fromhost, m_rdt;
  logic        m_err, m_halt;
  logic [30:0] m_exit;
  logic [7:0]  mq[$];

  typedef struct {
    logic        wen;
    logic [31:0] adr;
    logic [2:0]  fn3;
    logic [31:0] wdt;
    logic        hv;
    logic [31:0] hd;
    logic [31:0] exp_rdt;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'h0000, 8'(mq.size()), 5'b00000, (mq.size() == 0),
            (mq.size() == int'(DEP)), m_halt};
  endfunction

  function automatic logic m_rdy(input logic v, input logic w, input logic [31:0] a,
                                 input logic [2:0] f);
    logic word;
    word = (f[1:0] == 2'b10) && (a[1:0] == 2'b00);
    return !(CON_EN && v && w && word && (a[3:2] == 2'd2) && (mq.size() == int'(DEP)));
  endfunction

  task automatic model_reset();
    m_tohost = '0; m_fromhost = '0; m_rdt = '0; m_err = 1'b0;
    m_halt = 1'b0; m_exit = '0;
    mq.delete();
  endtask

  task automatic model_update(input logic t, input logic w, input logic [31:0] a,
                              input logic [2:0] f, input logic [31:0] d, input logic hv,
                              input logic [31:0] hd, input logic cr);
    logic word;
    logic [31:0] rd;
    logic pop;
    word = (f[1:0] == 2'b10) && (a[1:0] == 2'b00);
    case (a[3:2])
      2'd0:    rd = m_tohost;
      2'd1:    rd = m_fromhost;
      2'd2:    rd = 32'h0;
      default: rd = m_status();
    endcase
    pop = cr && (mq.size() > 0);
    if (t) begin
      m_err = !word;
      m_rdt = (word && !w) ? rd : 32'h0;
      if (word && w) begin
        case (a[3:2])
          2'd0: begin
            m_tohost = d;
            if (d[0] && !m_halt) begin
              m_halt = 1'b1;
              m_exit = d[31:1];
            end
          end
          2'd1: m_fromhost = d;
          2'd2: if (CON_EN) mq.push_back(d[7:0]);
          default: ;
        endcase
      end
    end
    if (hv) m_fromhost = hd;
    if (pop) void'(mq.pop_front());
  endtask

  task automatic check_outputs();
    chk("tcb_rdt", tcb_rdt, m_rdt);
    chk("tcb_err", 32'(tcb_err), 32'(m_err));
    chk("halt", 32'(halt), 32'(m_halt));
    chk("exit_code", 32'(exit_code), 32'(m_exit));
    chk("con_vld", 32'(con_vld), 32'(mq.size() > 0));
    chk("con_dat", 32'(con_dat), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
  endtask

  // One clock: drive at negedge, check ready, update model at posedge, check outputs.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [2:0] f, input logic [31:0] d, input logic hv,
                      input logic [31:0] hd, input logic cr);
    logic er;
    tcb_vld = v; tcb_wen = w; tcb_adr = a; tcb_fn3 = f; tcb_wdt = d;
    host_vld = hv; host_dat = hd; con_rdy = cr;
    #1;
    er = m_rdy(v, w, a, f);
    chk("tcb_rdy", 32'(tcb_rdy), 32'(er));
    @(posedge clk);
    model_update(v && er, w, a, f, d, hv, hd, cr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic cr);
    step(1'b0, 1'b0, A_TO, 3'b010, 32'h0, 1'b0, 32'h0, cr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs();
  endtask

  vec_t vt[16];
  logic [7:0] drain_exp [4];

  initial begin
    rst = 1'b1; tcb_vld = 1'b0; tcb_wen = 1'b0; tcb_adr = '0; tcb_fn3 = 3'b010;
    tcb_wdt = '0; host_vld = 1'b0; host_dat = '0; con_rdy = 1'b0;
    model_reset();
    do_reset();
    chk("rst_rdy", 32'(tcb_rdy), 32'h1);

    // directed vector table
    vt[0]  = '{1'b0, A_ST,           3'b010, 32'h0,        1'b0, 32'h0,        32'h0000_0004, 1'b0};
    vt[1]  = '{1'b1, A_TO,           3'b010, 32'h0000_002B, 1'b0, 32'h0,       32'h0,         1'b0};
    vt[2]  = '{1'b1, A_TO,           3'b010, 32'h0000_0003, 1'b0, 32'h0,       32'h0,         1'b0};
    vt[3]  = '{1'b0, A_TO,           3'b010, 32'h0,        1'b0, 32'h0,        32'h0000_0003, 1'b0};
    vt[4]  = '{1'b0, A_ST,           3'b010, 32'h0,        1'b0, 32'h0,        32'h0000_0005, 1'b0};
    vt[5]  = '{1'b1, A_FR,           3'b001, 32'h0000_1234, 1'b0, 32'h0,       32'h0,         1'b1};
    vt[6]  = '{1'b0, BASE + 32'h2,   3'b010, 32'h0,        1'b0, 32'h0,        32'h0,         1'b1};
    vt[7]  = '{1'b0, A_FR,           3'b010, 32'h0,        1'b0, 32'h0,        32'h0,         1'b0};
    vt[8]  = '{1'b1, A_FR,           3'b010, 32'h0,        1'b1, 32'hDEAD_BEEF, 32'h0,        1'b0};
    vt[9]  = '{1'b0, A_FR,           3'b010, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vt[10] = '{1'b1, A_CON,          3'b010, 32'h0000_0141, 1'b0, 32'h0,       32'h0,         1'b0};
    vt[11] = '{1'b0, A_CON,          3'b010, 32'h0,        1'b0, 32'h0,        32'h0,         1'b0};
    vt[12] = '{1'b1, A_ST,           3'b010, 32'hFFFF_FFFF, 1'b0, 32'h0,       32'h0,         1'b0};
    vt[13] = '{1'b0, A_ST,           3'b010, 32'h0,        1'b0, 32'h0,
               CON_EN ? 32'h0000_0101 : 32'h0000_0005, 1'b0};
    vt[14] = '{1'b0, A_TO,           3'b110, 32'h0,        1'b0, 32'h0,        32'h0000_0003, 1'b0};
    vt[15] = '{1'b0, A_TO,           3'b000, 32'h0,        1'b0, 32'h0,        32'h0,         1'b1};

    for (int i = 0; i < 16; i++) begin
      step(1'b1, vt[i].wen, vt[i].adr, vt[i].fn3, vt[i].wdt, vt[i].hv, vt[i].hd, 1'b0);
      chk($sformatf("vec%0d_rdt", i), tcb_rdt, vt[i].exp_rdt);
      chk($sformatf("vec%0d_err", i), 32'(tcb_err), 32'(vt[i].exp_err));
      if (i == 1) begin
        chk("halt_rise", 32'(halt), 32'h1);
        chk("exit_21", 32'(exit_code), 32'd21);
      end
    end
    chk("exit_sticky", 32'(exit_code), 32'd21);

    tcb_vld = 1'b0;
    do_reset();

    if (CON_EN) begin
      // fill, stall, single pop releases the stalled write, then drain in order
      for (int i = 0; i < 4; i++)
        step(1'b1, 1'b1, A_CON, 3'b010, 32'h41 + 32'(i), 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, A_CON, 3'b010, 32'h45, 1'b0, 32'h0, 1'b0);
      chk("stall_full", 32'(tcb_rdy), 32'h0);
      chk("head_41", 32'(con_dat), 32'h41);
      step(1'b1, 1'b1, A_CON, 3'b010, 32'h45, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, A_CON, 3'b010, 32'h45, 1'b0, 32'h0, 1'b0);
      drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("drain%0d", i), 32'(con_dat), 32'(drain_exp[i]));
        idle(1'b1);
      end
      chk("drained", 32'(con_vld), 32'h0);

      // reset while a console write is stalled
      for (int i = 0; i < 4; i++)
        step(1'b1, 1'b1, A_CON, 3'b010, 32'h60 + 32'(i), 1'b0, 32'h0, 1'b0);
      tcb_vld = 1'b1; tcb_wen = 1'b1; tcb_adr = A_CON; tcb_wdt = 32'h99;
      #1;
      chk("pre_rst_stall", 32'(tcb_rdy), 32'h0);
      do_reset();
      #1;
      chk("post_rst_rdy", 32'(tcb_rdy), 32'h1);
      step(1'b1, 1'b1, A_CON, 3'b010, 32'h99, 1'b0, 32'h0, 1'b0);
      chk("post_rst_push", 32'(con_dat), 32'h99);
    end else begin
      // console disabled: writes never stall and nothing comes out
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b1, A_CON, 3'b010, 32'h30 + 32'(i), 1'b0, 32'h0, 1'b0);
        chk("nocon_vld", 32'(con_vld), 32'h0);
      end
      step(1'b1, 1'b0, A_ST, 3'b010, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("nocon_status", tcb_rdt, 32'h0000_0004);
    end

    // randomized traffic against the reference model
    tcb_vld = 1'b0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      logic [2:0]  f;
      logic        hv;
      logic [31:0] d;
      if (n == 750) begin
        tcb_vld = 1'b0;
        do_reset();
      end
      a = BASE | {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
      f = {1'($urandom), 2'b10};
      if ($urandom_range(0, 7) == 0) f = 3'($urandom);
      d = $urandom;
      if ((a[3:2] == 2'd0) && ($urandom_range(0, 3) != 0)) d[0] = 1'b0;
      hv = ($urandom_range(0, 7) == 0);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, f, d, hv, $urandom,
           1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/r5p_htif_responder.md
# r5p_htif_responder

TCB responder implementing a minimal HTIF-style host interface (tohost/fromhost mailbox, halt/exit-code capture, console byte output) for R5P cores. It sits on the common half-duplex TCB system bus next to memory. It gives simulation and FPGA builds a synthesizable replacement for testbench-side tohost snooping. The bus side follows the RISC-V TCB mode with DLY=1.

## Interface
- `BASE`, `32'h8020_0000`: base address of the 16-byte register window. The address decoder upstream selects the block; only `tcb_adr[3:0]` is used internally.
- `FIFO_DEP`, `4`: console FIFO depth in bytes. Must be a power of 2, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `tcb_vld` in 1: request valid.
- `tcb_wen` in 1: write enable.
- `tcb_adr` in 32: byte address.
- `tcb_fn3` in 3: `{uns, siz[1:0]}`.
- `tcb_wdt` in 32: write data.
- `tcb_rdt` out 32: read data, DLY=1.
- `tcb_err` out 1: response error, DLY=1.
- `tcb_rdy` out 1: ready, combinational.
- `host_vld` in 1: host-side fromhost write strobe.
- `host_dat` in 32: host-side fromhost value.
- `halt` out 1: sticky halt flag.
- `exit_code` out 31: halt exit code.
- `con_vld` out 1: console byte valid.
- `con_dat` out 8: console byte.
- `con_rdy` in 1: console sink ready.

## Operation
- Register map (offset `tcb_adr[3:2]`):
  - 0x0 TOHOST, rw.
  - 0x4 FROMHOST, rw.
  - 0x8 CONSOLE, wo, reads 0.
  - 0xC STATUS, ro, writes ignored without error.
- Transfer: `trn = tcb_vld & tcb_rdy`. All side effects happen only on `trn`.
- Access rules: only word access is accepted (`tcb_fn3[1:0]==2'b10`, `tcb_adr[1:0]==0`). Any other access completes with `tcb_err=1` and `tcb_rdt=0`, and has no side effect.
- TOHOST write:
  - Always stores `wdt`.
  - If `wdt[0]=1`, sets `halt<=1` and `exit_code<=wdt[31:1]`.
  - `halt` is sticky until `rst`. Later TOHOST writes still update the register but never change `exit_code` once halted.
- FROMHOST:
  - A CPU write stores `wdt`; software writes 0 to acknowledge.
  - `host_vld` loads `host_dat`.
  - If a CPU write and `host_vld` occur in the same cycle, the host value wins.
- CONSOLE write pushes `wdt[7:0]` into the FIFO.
- Console FIFO:
  - Pop on `con_vld & con_rdy`.
  - `con_vld = !empty`; `con_dat` is the head entry.
  - Push and pop in the same cycle are both performed and the level is unchanged.
- STATUS read: `[0]` halt, `[1]` FIFO full, `[2]` FIFO empty, `[15:8]` FIFO level, all other bits 0.
- Backpressure:
  - `tcb_rdy=0` only while `tcb_vld & tcb_wen & (offset==0x8) & full & word access`.
  - `tcb_rdy` does not depend on `con_rdy` in the same cycle. A full FIFO stalls even if a pop is occurring.
- Reset values: `tcb_rdt=0`, `tcb_err=0`, `halt=0`, `exit_code=0`, TOHOST=0, FROMHOST=0, FIFO empty (`con_vld=0`, `con_dat=0`).

## Timing
- Request accepted in cycle N. `tcb_rdt`/`tcb_err` are valid in cycle N+1 and hold until the next transfer's response.
- Write responses: `tcb_rdt=0`, with `tcb_err` per the access rules.
- Register updates from cycle-N writes are visible at N+1:
  - Read-after-write back-to-back (write in N, read in N+1) returns the new value at N+2.
  - `halt` rises at N+1.
- A console byte pushed in cycle N gives `con_vld=1` at N+1 when the FIFO was empty. There is no bypass.
- FIFO pointers are `log2(FIFO_DEP)+1` bits wide and wrap naturally. Level = `wptr - rptr`, truncated to 8 bits in STATUS.
- Reset asserted mid-stall: the stall and FIFO contents are discarded, and `tcb_rdy=1` on the cycle after `rst` deasserts.

## Configuration
- `R5P_HTIF_CONSOLE_EN`:
  - Defined: the console FIFO and the `con_*` stream are implemented as described.
  - Undefined:
    - No FIFO storage is built.
    - CONSOLE writes complete with `tcb_err=0` and are discarded; `tcb_rdy` never deasserts.
    - STATUS reads `[1]=0`, `[2]=1`, `[15:8]=0`.
    - `con_vld=0`, `con_dat=0`.

## Test plan
- Reset then read STATUS: `tcb_rdt=32'h0000_0004`, `tcb_err=0` in the response cycle; `halt=0`.
- Write TOHOST `32'h0000_002B`: `halt=1` and `exit_code=21` on the next cycle. A further write of `32'h0000_0003` leaves `exit_code=21`; reading TOHOST returns `32'h0000_0003`.
- With `con_rdy=0`, write CONSOLE bytes `0x41..0x45`: the first 4 complete and the 5th stalls with `tcb_rdy=0`. Raising `con_rdy` for one cycle pops `0x41`, after which the 5th write completes. Bytes drain in order `0x42,0x43,0x44,0x45`.
- Half-word write (`fn3=3'b001`) to FROMHOST and word read at address `BASE+2`: both give `tcb_err=1`. FROMHOST is unchanged.
- CPU writes FROMHOST `0x0` in the same cycle as `host_vld=1`, `host_dat=32'hDEAD_BEEF`: the following read returns `32'hDEAD_BEEF`.
- Build without `R5P_HTIF_CONSOLE_EN` and write CONSOLE 10 times: `tcb_rdy` stays 1, `con_vld` stays 0, and STATUS reads `32'h0000_0004`.
